// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader and the
// datapath stages that consume instruction words.
package imem_boot_loader_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_addr_counter.sv
// Word-address counter shared by program load and zero-fill; one bit wider
// than the address so it saturates at DEPTH instead of wrapping.
module imem_addr_counter #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              full
);

  localparam int CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0] count;

  // Counter register: clear wins over increment, and it never passes DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {CNT_W{1'b0}};
    end else if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (inc && !full) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign addr = count[ADDR_W-1:0];
  assign last = (count == CNT_W'(DEPTH - 1));
  assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program into instruction memory, zero-fills the remainder, then
// releases the datapath; holds the datapath off while any load is active.
import imem_boot_loader_pkg::*;

module imem_boot_loader #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 256,
  parameter logic [INSTR_W-1:0] NOP_WORD = imem_boot_loader_pkg::NOP_WORD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_valid,
  input  logic [INSTR_W-1:0] s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_run,
  output logic               done,
  output logic               overflow,
  output logic [ADDR_W:0]    word_count,
  output logic [INSTR_W-1:0] checksum
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            state;
  logic              drain;
  logic              load_xfer;
  logic              fill_wr;
  logic              cnt_clear;
  logic              cnt_inc;
  logic              addr_last;
  logic              addr_full;
  logic [ADDR_W-1:0] addr;

  assign load_xfer = (state == LOAD) && s_valid;
  assign fill_wr   = (state == FILL);
  assign cnt_clear = start && ((state == IDLE) || (state == RUN));
  assign cnt_inc   = (load_xfer || fill_wr) && !addr_full;

  imem_addr_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .addr  (addr),
    .last  (addr_last),
    .full  (addr_full)
  );

  // The write port is driven straight from the stream so a word lands in the
  // same cycle it is accepted; drained overflow words never reach memory.
  assign s_ready  = (state == LOAD) || ((state == RUN) && drain);
  assign im_we    = cnt_inc;
  assign im_addr  = addr;
  assign im_wdata = load_xfer ? s_data : (fill_wr ? NOP_WORD : {INSTR_W{1'b0}});
  assign cpu_run  = (state == RUN) && !drain;
  assign done     = (state == RUN);

  // Load sequencer with its statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain      <= 1'b0;
      overflow   <= 1'b0;
      word_count <= {CNT_W{1'b0}};
      checksum   <= {INSTR_W{1'b0}};
    end else begin
      case (state)
        IDLE, RUN: begin
          if (start) begin
            state      <= LOAD;
            drain      <= 1'b0;
            overflow   <= 1'b0;
            word_count <= {CNT_W{1'b0}};
            checksum   <= {INSTR_W{1'b0}};
          end else if ((state == RUN) && drain && s_valid) begin
            overflow <= 1'b1;
            drain    <= !s_last;
          end else begin
            state <= state;
          end
        end
        LOAD: begin
          if (s_valid) begin
            word_count <= word_count + CNT_W'(1);
            checksum   <= checksum + s_data;
            // A full memory without s_last switches to dropping the excess.
            if (addr_last) begin
              state <= RUN;
              drain <= !s_last;
            end else if (s_last) begin
              state <= FILL;
            end else begin
              state <= LOAD;
            end
          end else begin
            state <= LOAD;
          end
        end
        FILL: begin
          if (addr_last) begin
            state <= RUN;
          end else begin
            state <= FILL;
          end
        end
        default: begin
          state <= IDLE;
          drain <= 1'b0;
        end
      endcase
    end
  end

endmodule
